// File: rtl/twos_to_sm.sv
// Bit-serial two's-complement to sign-magnitude converter, LSB first.
// The result uses the "copy up to the first 1, then invert" rule for negation.
module twos_to_sm #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_sign,
  output logic [WIDTH-1:0] out_mag,
  output logic             out_min_neg,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int IW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] data;
  logic [IW-1:0]    idx;
  logic             seen_one;
  logic             cur_bit;
  logic             mag_bit;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // Negative operands pass bits through until the first 1, then invert the rest.
  always_comb begin
    cur_bit = data[idx];
    mag_bit = (out_sign && seen_one) ? ~cur_bit : cur_bit;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      data        <= '0;
      idx         <= '0;
      seen_one    <= 1'b0;
      out_sign    <= 1'b0;
      out_mag     <= '0;
      out_min_neg <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            data        <= in_data;
            out_sign    <= in_data[WIDTH-1];
            out_min_neg <= (in_data == MIN_NEG);
            idx         <= '0;
            seen_one    <= 1'b0;
            state       <= SHIFT;
          end
        end
        SHIFT: begin
          out_mag[idx] <= mag_bit;
          if (out_sign && cur_bit)
            seen_one <= 1'b1;
          if (idx == LAST_IDX)
            state <= DONE;
          else
            idx <= idx + 1'b1;
        end
        DONE: begin
          if (out_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_twos_to_sm.sv
// Self-checking bench for twos_to_sm: scoreboard queue filled at acceptance,
// drained by a monitor on each output handshake, with directed corner cases.
module tb_twos_to_sm;

  localparam int W = 5;

  typedef struct packed {
    logic         sign;
    logic [W-1:0] mag;
    logic         min_neg;
  } result_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] in_data = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         out_sign;
  logic [W-1:0] out_mag;
  logic         out_min_neg;
  logic         out_valid;
  logic         out_ready = 1'b1;

  int      total = 0;
  int      bad = 0;
  result_t exp_q[$];
  bit      rand_phase = 1'b0;
  time     accept_time = 0;

  twos_to_sm #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_sign(out_sign), .out_mag(out_mag),
    .out_min_neg(out_min_neg), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  // Reference: signed value, absolute value, and the lone unrepresentable negative.
  function automatic result_t model(input logic [W-1:0] d);
    result_t r;
    int v;
    v = $signed(d);
    r.sign = (v < 0);
    r.mag = W'((v < 0) ? -v : v);
    r.min_neg = (v == -(1 << (W - 1)));
    return r;
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Present one operand once the DUT is ready; returns 2 time units after the accepting edge.
  task automatic apply_stimulus(input logic [W-1:0] d);
    int n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #2;
      n++;
    end
    check_output("ready_timeout", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_data = d;
    exp_q.push_back(model(d));
    @(posedge clk);
    accept_time = $time;
    #2;
    in_valid = 1'b0;
    in_data = W'($urandom);
  endtask

  task automatic wait_result(output int cycles);
    cycles = 0;
    while (!out_valid && cycles < 50) begin
      @(posedge clk); #2;
      cycles++;
    end
  endtask

  // Monitor: compare every result that is handed off downstream.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check_output("unexpected_output", {31'd0, out_valid}, 32'd0);
      end else begin
        result_t e;
        e = exp_q.pop_front();
        check_output("out_sign", {31'd0, out_sign}, {31'd0, e.sign});
        check_output("out_mag", {27'd0, out_mag}, {27'd0, e.mag});
        check_output("out_min_neg", {31'd0, out_min_neg}, {31'd0, e.min_neg});
      end
    end
  end

  // Random backpressure while the random phase runs.
  always begin
    @(posedge clk); #2;
    if (rand_phase)
      out_ready = ($urandom_range(0, 3) != 0);
  end

  initial begin
    int lat;
    time t0;
    result_t held;
    logic [W-1:0] vec [6];
    vec[0] = 5'b10110; vec[1] = 5'b01101; vec[2] = 5'b10000;
    vec[3] = 5'b11111; vec[4] = 5'b00000; vec[5] = 5'b01111;

    #3;
    check_output("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check_output("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_output("rst_out_sign", {31'd0, out_sign}, 32'd0);
    check_output("rst_out_mag", {27'd0, out_mag}, 32'd0);
    check_output("rst_out_min_neg", {31'd0, out_min_neg}, 32'd0);
    @(posedge clk); #2;
    rst = 1'b0;
    @(posedge clk); #2;
    check_output("idle_in_ready", {31'd0, in_ready}, 32'd1);

    // Directed vectors with out_ready tied high: latency and results.
    foreach (vec[i]) begin
      apply_stimulus(vec[i]);
      wait_result(lat);
      check_output("latency", lat, W);
    end

    // Back-to-back throughput with out_ready high.
    apply_stimulus(5'b00011);
    t0 = accept_time;
    apply_stimulus(5'b11100);
    check_output("throughput_cycles", 32'((accept_time - t0) / 10), W + 2);
    wait_result(lat);
    @(posedge clk); #2;

    // Backpressure in DONE while new input is offered.
    out_ready = 1'b0;
    apply_stimulus(5'b10110);
    held = model(5'b10110);
    wait_result(lat);
    check_output("bp_latency", lat, W);
    in_valid = 1'b1;
    in_data = 5'b00101;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #2;
      check_output("bp_out_valid", {31'd0, out_valid}, 32'd1);
      check_output("bp_in_ready", {31'd0, in_ready}, 32'd0);
      check_output("bp_out_sign", {31'd0, out_sign}, {31'd0, held.sign});
      check_output("bp_out_mag", {27'd0, out_mag}, {27'd0, held.mag});
      check_output("bp_out_min_neg", {31'd0, out_min_neg}, {31'd0, held.min_neg});
    end
    out_ready = 1'b1;
    @(posedge clk); #2;
    check_output("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
    exp_q.push_back(model(5'b00101));
    @(posedge clk); #2;
    in_valid = 1'b0;
    wait_result(lat);
    check_output("bp_next_latency", lat, W);
    @(posedge clk); #2;

    // Reset in the third SHIFT cycle aborts with no result.
    apply_stimulus(5'b11001);
    @(posedge clk); #2;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check_output("abort_out_valid", {31'd0, out_valid}, 32'd0);
    check_output("abort_in_ready", {31'd0, in_ready}, 32'd1);
    check_output("abort_out_sign", {31'd0, out_sign}, 32'd0);
    check_output("abort_out_mag", {27'd0, out_mag}, 32'd0);
    check_output("abort_out_min_neg", {31'd0, out_min_neg}, 32'd0);
    exp_q.delete();
    @(posedge clk); #2;
    rst = 1'b0;
    begin
      int pulses = 0;
      for (int c = 0; c < 10; c++) begin
        @(posedge clk); #2;
        if (out_valid) pulses++;
      end
      check_output("abort_no_pulse", pulses, 0);
    end
    apply_stimulus(5'b10011);
    wait_result(lat);
    check_output("post_abort_latency", lat, W);
    @(posedge clk); #2;

    // Randomized operands under random backpressure.
    rand_phase = 1'b1;
    for (int k = 0; k < 60; k++)
      apply_stimulus(W'($urandom));
    rand_phase = 1'b0;
    @(posedge clk); #3;
    out_ready = 1'b1;

    begin
      int n = 0;
      while (exp_q.size() > 0 && n < 200) begin
        @(posedge clk);
        n++;
      end
      check_output("drain_pending", exp_q.size(), 0);
    end
    @(posedge clk); #2;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
